circ_ras_ckpt: RTL and testbench

- Parametrised circular return-address stack for the branch-prediction front end.
- Calls push and returns pop.
- On overflow, a push overwrites the oldest entry (wrap-around); pops never wrap below the current count.
- Adds simultaneous push+pop, numbered speculative checkpoints with single-cycle recovery, flush, and overflow/underflow event flags.

---
 rtl/circ_ras_ckpt_pkg.sv | 21 ++
 rtl/ras_ckpt_bank.sv | 28 ++
 rtl/circ_ras_ckpt.sv | 150 +++++++++++++++
 tb/tb_circ_ras_ckpt.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/circ_ras_ckpt_pkg.sv
// Shared defaults and checkpoint record layout for the circular return-address stack.
// Record layout, MSB to LSB: {tos[PTRW], count[PTRW+1], top[DWIDTH]}.
package circ_ras_ckpt_pkg;

  localparam int unsigned DEF_DWIDTH = 32;
  localparam int unsigned DEF_DEPTH  = 8;
  localparam int unsigned DEF_NCKPT  = 4;

  function automatic int unsigned ckpt_rec_w(int unsigned ptrw, int unsigned dwidth);
    return 2 * ptrw + 1 + dwidth;
  endfunction

  function automatic int unsigned ckpt_cnt_off(int unsigned dwidth);
    return dwidth;
  endfunction

  function automatic int unsigned ckpt_tos_off(int unsigned ptrw, int unsigned dwidth);
    return dwidth + ptrw + 1;
  endfunction

endpackage

// File: rtl/ras_ckpt_bank.sv
// Checkpoint register file: one synchronous write port, one combinational read port.
module ras_ckpt_bank #(
  parameter int unsigned NCKPT = 4,
  parameter int unsigned CKW   = 2,
  parameter int unsigned RECW  = 38
) (
  input  logic            Clk,
  input  logic            Rest,
  input  logic            we,
  input  logic [CKW-1:0]  waddr,
  input  logic [RECW-1:0] wdata,
  input  logic [CKW-1:0]  raddr,
  output logic [RECW-1:0] rdata
);

  logic [RECW-1:0] slot_q [NCKPT];

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      for (int i = 0; i < int'(NCKPT); i++) slot_q[i] <= '0;
    end else if (we) begin
      slot_q[waddr] <= wdata;
    end
  end

  assign rdata = slot_q[raddr];

endmodule

// File: rtl/circ_ras_ckpt.sv
// Circular return-address stack with numbered speculative checkpoints, flush and
// overflow/underflow pulses. Overflowing pushes overwrite the oldest entry.
module circ_ras_ckpt
  import circ_ras_ckpt_pkg::*;
#(
  parameter int unsigned DWIDTH = DEF_DWIDTH,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned PTRW   = 3,
  parameter int unsigned NCKPT  = DEF_NCKPT,
  parameter int unsigned CKW    = 2
) (
  input  logic              Clk,
  input  logic              Rest,
  input  logic              Push,
  input  logic [DWIDTH-1:0] PushData,
  input  logic              Pop,
  output logic [DWIDTH-1:0] PopData,
  output logic              PopValid,
  output logic [DWIDTH-1:0] Top,
  input  logic              CkptSave,
  input  logic [CKW-1:0]    CkptSaveId,
  input  logic              Recover,
  input  logic [CKW-1:0]    RecoverId,
  input  logic              Flush,
  output logic [PTRW:0]     Count,
  output logic              Full,
  output logic              Empty,
  output logic              Overflow,
  output logic              Underflow
);

  localparam int unsigned RECW    = ckpt_rec_w(PTRW, DWIDTH);
  localparam int unsigned OFF_CNT = ckpt_cnt_off(DWIDTH);
  localparam int unsigned OFF_TOS = ckpt_tos_off(PTRW, DWIDTH);
  localparam logic [PTRW:0] FULL_CNT = (PTRW + 1)'(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]   tos_q, tos_d, top_idx;
  logic [PTRW:0]     count_q, count_d;
  logic [DWIDTH-1:0] popdata_q, popdata_d;
  logic              popvalid_q, popvalid_d, ovf_q, ovf_d, udf_q, udf_d;
  logic              mem_we;
  logic [PTRW-1:0]   mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;

  logic [RECW-1:0]   rec_rd, rec_wd;
  logic [PTRW-1:0]   slot_tos;
  logic [PTRW:0]     slot_cnt;
  logic [DWIDTH-1:0] slot_top;

  assign top_idx  = tos_q - 1'b1;
  assign Empty    = (count_q == '0);
  assign Full     = (count_q == FULL_CNT);
  assign Count    = count_q;
  assign Top      = Empty ? '0 : mem[top_idx];
  assign PopData  = popdata_q;
  assign PopValid = popvalid_q;
  assign Overflow = ovf_q;
  assign Underflow = udf_q;

  assign slot_tos = rec_rd[OFF_TOS +: PTRW];
  assign slot_cnt = rec_rd[OFF_CNT +: PTRW + 1];
  assign slot_top = rec_rd[DWIDTH-1:0];

  // A save in a flush/recover cycle captures the post-flush/post-recover state.
  always_comb begin
    if (Flush)        rec_wd = '0;
    else if (Recover) rec_wd = rec_rd;
    else              rec_wd = {tos_q, count_q, Top};
  end

  ras_ckpt_bank #(
    .NCKPT (NCKPT),
    .CKW   (CKW),
    .RECW  (RECW)
  ) u_bank (
    .Clk   (Clk),
    .Rest  (Rest),
    .we    (CkptSave),
    .waddr (CkptSaveId),
    .wdata (rec_wd),
    .raddr (RecoverId),
    .rdata (rec_rd)
  );

  always_comb begin
    tos_d      = tos_q;
    count_d    = count_q;
    popdata_d  = popdata_q;
    popvalid_d = 1'b0;
    ovf_d      = 1'b0;
    udf_d      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = tos_q;
    mem_wdata  = PushData;
    if (Flush) begin
      tos_d   = '0;
      count_d = '0;
    end else if (Recover) begin
      tos_d   = slot_tos;
      count_d = slot_cnt;
      if (slot_cnt != '0) begin
        mem_we    = 1'b1;
        mem_waddr = slot_tos - 1'b1;
        mem_wdata = slot_top;
      end
    end else if (Push && Pop && !Empty) begin
      popdata_d  = mem[top_idx];
      popvalid_d = 1'b1;
      mem_we     = 1'b1;
      mem_waddr  = top_idx;
    end else if (Push) begin
      mem_we = 1'b1;
      tos_d  = tos_q + 1'b1;
      udf_d  = Pop;
      if (Full) ovf_d = 1'b1;
      else      count_d = count_q + 1'b1;
    end else if (Pop) begin
      if (Empty) begin
        udf_d = 1'b1;
      end else begin
        popdata_d  = mem[top_idx];
        popvalid_d = 1'b1;
        tos_d      = top_idx;
        count_d    = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      tos_q      <= '0;
      count_q    <= '0;
      popdata_q  <= '0;
      popvalid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      tos_q      <= tos_d;
      count_q    <= count_d;
      popdata_q  <= popdata_d;
      popvalid_q <= popvalid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      if (mem_we) mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_circ_ras_ckpt.sv
// Directed self-checking bench for circ_ras_ckpt (DEPTH=8, NCKPT=4).
module tb_circ_ras_ckpt;

  logic        Clk = 1'b0;
  logic        Rest;
  logic        Push, Pop, CkptSave, Recover, Flush;
  logic [31:0] PushData;
  logic [1:0]  CkptSaveId, RecoverId;
  logic [31:0] PopData, Top;
  logic        PopValid, Full, Empty, Overflow, Underflow;
  logic [3:0]  Count;

  int n_assert = 0;
  int n_fail   = 0;

  circ_ras_ckpt #(
    .DWIDTH (32),
    .DEPTH  (8),
    .PTRW   (3),
    .NCKPT  (4),
    .CKW    (2)
  ) dut (
    .Clk        (Clk),
    .Rest       (Rest),
    .Push       (Push),
    .PushData   (PushData),
    .Pop        (Pop),
    .PopData    (PopData),
    .PopValid   (PopValid),
    .Top        (Top),
    .CkptSave   (CkptSave),
    .CkptSaveId (CkptSaveId),
    .Recover    (Recover),
    .RecoverId  (RecoverId),
    .Flush      (Flush),
    .Count      (Count),
    .Full       (Full),
    .Empty      (Empty),
    .Overflow   (Overflow),
    .Underflow  (Underflow)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    Push = 0; Pop = 0; CkptSave = 0; Recover = 0; Flush = 0;
    PushData = '0; CkptSaveId = '0; RecoverId = '0;
  endtask

  task automatic do_push(input logic [31:0] d);
    Push = 1; PushData = d; cyc(); Push = 0;
  endtask

  task automatic do_pop();
    Pop = 1; cyc(); Pop = 0;
  endtask

  initial begin
    clr();
    Rest = 1;
    #12;
    check("rst_count", 64'(Count), 0);
    check("rst_empty", 64'(Empty), 1);
    check("rst_full", 64'(Full), 0);
    check("rst_top", 64'(Top), 0);
    check("rst_popdata", 64'(PopData), 0);
    check("rst_popvalid", 64'(PopValid), 0);
    check("rst_ovf", 64'(Overflow), 0);
    check("rst_udf", 64'(Underflow), 0);
    Rest = 0;

    // Basic push/pop
    do_push(32'h100); do_push(32'h200); do_push(32'h300);
    check("push3_count", 64'(Count), 3);
    check("push3_top", 64'(Top), 32'h300);
    do_pop();
    check("pop_data", 64'(PopData), 32'h300);
    check("pop_valid", 64'(PopValid), 1);
    check("pop_top", 64'(Top), 32'h200);
    check("pop_count", 64'(Count), 2);

    // Simultaneous push+pop replaces top
    Push = 1; Pop = 1; PushData = 32'h500; cyc(); clr();
    check("pp_data", 64'(PopData), 32'h200);
    check("pp_valid", 64'(PopValid), 1);
    check("pp_top", 64'(Top), 32'h500);
    check("pp_count", 64'(Count), 2);
    cyc();
    check("pp_valid_pulse", 64'(PopValid), 0);

    Flush = 1; cyc(); clr();
    check("flush_count", 64'(Count), 0);
    check("flush_empty", 64'(Empty), 1);

    // Overflow wrap
    for (int i = 1; i <= 8; i++) do_push(32'(i));
    check("p8_full", 64'(Full), 1);
    check("p8_ovf", 64'(Overflow), 0);
    do_push(32'd9);
    check("p9_ovf", 64'(Overflow), 1);
    check("p9_count", 64'(Count), 8);
    check("p9_full", 64'(Full), 1);
    check("p9_top", 64'(Top), 9);
    cyc();
    check("ovf_pulse", 64'(Overflow), 0);
    for (int i = 9; i >= 2; i--) begin
      do_pop();
      check("wrap_pop", 64'(PopData), 64'(i));
    end
    check("wrap_empty", 64'(Empty), 1);

    // Underflow
    do_pop();
    check("udf_flag", 64'(Underflow), 1);
    check("udf_valid", 64'(PopValid), 0);
    check("udf_count", 64'(Count), 0);
    check("udf_hold", 64'(PopData), 2);
    cyc();
    check("udf_pulse", 64'(Underflow), 0);

    // Checkpoint save/recover
    do_push(32'h10); do_push(32'h20);
    CkptSave = 1; CkptSaveId = 2; cyc(); clr();
    do_pop();
    check("ck_pop", 64'(PopData), 32'h20);
    do_push(32'h99); do_push(32'h77);
    check("ck_pre_count", 64'(Count), 3);
    Recover = 1; RecoverId = 2; Push = 1; PushData = 32'hdead; cyc(); clr();
    check("rec_count", 64'(Count), 2);
    check("rec_top", 64'(Top), 32'h20);
    check("rec_valid", 64'(PopValid), 0);
    do_pop();
    check("rec_pop1", 64'(PopData), 32'h20);
    do_pop();
    check("rec_pop2", 64'(PopData), 32'h10);
    check("rec_empty", 64'(Empty), 1);

    // Save during recover captures the restored state
    Recover = 1; RecoverId = 2; CkptSave = 1; CkptSaveId = 3; cyc(); clr();
    check("sr_count", 64'(Count), 2);
    Flush = 1; cyc(); clr();
    Recover = 1; RecoverId = 3; cyc(); clr();
    check("sr3_count", 64'(Count), 2);
    check("sr3_top", 64'(Top), 32'h20);

    // Save during flush captures the empty state
    CkptSave = 1; CkptSaveId = 1; Flush = 1; cyc(); clr();
    do_push(32'hbb);
    Recover = 1; RecoverId = 1; cyc(); clr();
    check("sf_count", 64'(Count), 0);
    check("sf_top", 64'(Top), 0);

    // Flush beats recover
    do_push(32'hcc);
    Flush = 1; Recover = 1; RecoverId = 2; cyc(); clr();
    check("fr_count", 64'(Count), 0);
    check("fr_empty", 64'(Empty), 1);

    // Asynchronous reset mid-push
    do_push(32'h41); do_push(32'h42); do_pop();
    check("pre_rst_valid", 64'(PopValid), 1);
    Push = 1; PushData = 32'h123;
    Rest = 1;
    #1;
    check("arst_count", 64'(Count), 0);
    check("arst_top", 64'(Top), 0);
    check("arst_popdata", 64'(PopData), 0);
    check("arst_popvalid", 64'(PopValid), 0);
    check("arst_empty", 64'(Empty), 1);
    #2;
    Rest = 0;
    clr();
    do_pop();
    check("post_rst_udf", 64'(Underflow), 1);
    check("post_rst_count", 64'(Count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
